// File: rtl/lsq_store_arbiter_if.sv
// Store-side bundle: NUM_PORTS circuit requesters on one side,
// a single memory/LSQ store port (address + data) on the other.
interface lsq_store_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] dataIn;
  logic [NUM_PORTS-1:0]            dataIn_valid;
  logic [NUM_PORTS-1:0]            dataIn_ready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addrIn;
  logic [NUM_PORTS-1:0]            addrIn_valid;
  logic [NUM_PORTS-1:0]            addrIn_ready;
  logic [DATA_WIDTH-1:0]           dataToMem;
  logic                            dataToMem_valid;
  logic                            dataToMem_ready;
  logic [ADDR_WIDTH-1:0]           addrOut;
  logic                            addrOut_valid;
  logic                            addrOut_ready;
  logic [NUM_PORTS-1:0]            grantOut;

  modport slave (
    input  dataIn,
    input  dataIn_valid,
    output dataIn_ready,
    input  addrIn,
    input  addrIn_valid,
    output addrIn_ready,
    output dataToMem,
    output dataToMem_valid,
    input  dataToMem_ready,
    output addrOut,
    output addrOut_valid,
    input  addrOut_ready,
    output grantOut
  );

  modport master (
    output dataIn,
    output dataIn_valid,
    input  dataIn_ready,
    output addrIn,
    output addrIn_valid,
    input  addrIn_ready,
    input  dataToMem,
    input  dataToMem_valid,
    output dataToMem_ready,
    input  addrOut,
    input  addrOut_valid,
    output addrOut_ready,
    input  grantOut
  );
endinterface

// File: rtl/lsq_store_arbiter.sv
// Round-robin store arbiter: picks one addr+data pair per cycle
// into a one-entry register whose two output channels drain independently.
module lsq_store_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  lsq_store_arbiter_if.slave bus
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);
  localparam logic [PW:0] NP = (PW+1)'(NUM_PORTS);

  logic                  full;
  logic                  addr_done;
  logic                  data_done;
  logic [PW-1:0]         prio;
  logic [PW-1:0]         prio_nxt;
  logic [PW-1:0]         win;
  logic [PW-1:0]         cand;
  logic [PW:0]           sum;
  logic                  found;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  grant_d;
  logic [NUM_PORTS-1:0]  grant_q;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  addr_vld;
  logic                  data_vld;
  logic                  addr_fire;
  logic                  data_fire;
  logic                  free_now;
  logic                  load;

  assign req = bus.addrIn_valid & bus.dataIn_valid;

  // Scan prio, prio+1, ... with wrap; first requester wins.
  always_comb begin
    win   = prio;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, prio} + (PW+1)'(k);
      if (sum >= NP)
        sum = sum - NP;
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_d      = '0;
    grant_d[win] = 1'b1;
  end

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PW'(i) == win) begin
        addr_sel = bus.addrIn[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_sel = bus.dataIn[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign prio_nxt = (win == LAST) ? '0 : win + PW'(1);

  assign addr_vld  = full & ~addr_done;
  assign data_vld  = full & ~data_done;
  assign addr_fire = addr_vld & bus.addrOut_ready;
  assign data_fire = data_vld & bus.dataToMem_ready;

  assign free_now = full
                  & (addr_done | bus.addrOut_ready)
                  & (data_done | bus.dataToMem_ready);

  // Gated by rst so readies drop the moment reset asserts.
  assign load = rst & (|req) & (~full | free_now);

  assign bus.addrIn_ready = load ? grant_d : '0;
  assign bus.dataIn_ready = load ? grant_d : '0;

  assign bus.addrOut         = addr_q;
  assign bus.addrOut_valid   = addr_vld;
  assign bus.dataToMem       = data_q;
  assign bus.dataToMem_valid = data_vld;
  assign bus.grantOut        = grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full      <= 1'b0;
      addr_done <= 1'b0;
      data_done <= 1'b0;
      prio      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      grant_q   <= '0;
    end else if (load) begin
      full      <= 1'b1;
      addr_done <= 1'b0;
      data_done <= 1'b0;
      prio      <= prio_nxt;
      addr_q    <= addr_sel;
      data_q    <= data_sel;
      grant_q   <= grant_d;
    end else if (free_now) begin
      full      <= 1'b0;
      addr_done <= 1'b0;
      data_done <= 1'b0;
      grant_q   <= '0;
    end else begin
      if (addr_fire)
        addr_done <= 1'b1;
      if (data_fire)
        data_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsq_store_arbiter.sv
// Directed bench for lsq_store_arbiter: 2-port instance for the main
// sequence, 3-port instance for priority wrap.
module tb_lsq_store_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  lsq_store_arbiter_if #(
    .NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)
  ) b2 ();

  lsq_store_arbiter_if #(
    .NUM_PORTS(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)
  ) b3 ();

  lsq_store_arbiter #(
    .NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)
  ) u2 (
    .clk(clk),
    .rst(rst),
    .bus(b2)
  );

  lsq_store_arbiter #(
    .NUM_PORTS(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)
  ) u3 (
    .clk(clk),
    .rst(rst),
    .bus(b3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv2(input logic [1:0] av,
                      input logic [1:0] dv,
                      input logic [31:0] a0,
                      input logic [31:0] d0,
                      input logic [31:0] a1,
                      input logic [31:0] d1);
    b2.addrIn_valid = av;
    b2.dataIn_valid = dv;
    b2.addrIn       = {a1, a0};
    b2.dataIn       = {d1, d0};
  endtask

  task automatic rdy2(input string tag, input logic [1:0] exp);
    chk({tag, ".ardy"}, 64'(b2.addrIn_ready), 64'(exp));
    chk({tag, ".drdy"}, 64'(b2.dataIn_ready), 64'(exp));
  endtask

  task automatic out2(input string tag,
                      input logic av,
                      input logic dv,
                      input logic [1:0] g,
                      input logic [31:0] a,
                      input logic [31:0] d);
    chk({tag, ".avld"}, 64'(b2.addrOut_valid), 64'(av));
    chk({tag, ".dvld"}, 64'(b2.dataToMem_valid), 64'(dv));
    chk({tag, ".gnt"}, 64'(b2.grantOut), 64'(g));
    chk({tag, ".addr"}, 64'(b2.addrOut), 64'(a));
    chk({tag, ".data"}, 64'(b2.dataToMem), 64'(d));
  endtask

  initial begin
    drv2(2'b11, 2'b11, 32'h1, 32'h2, 32'h3, 32'h4);
    b2.addrOut_ready   = 1'b1;
    b2.dataToMem_ready = 1'b1;
    b3.addrIn       = {32'h302, 32'h301, 32'h300};
    b3.dataIn       = {32'h3002, 32'h3001, 32'h3000};
    b3.addrIn_valid = '0;
    b3.dataIn_valid = '0;
    b3.addrOut_ready   = 1'b1;
    b3.dataToMem_ready = 1'b1;

    // Reset: readies low even though every port requests
    #2;
    rdy2("rst", 2'b00);
    out2("rst", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drv2(2'b00, 2'b00, 0, 0, 0, 0);
    #1 rst = 1'b1;

    // Single request from port 0
    step();
    drv2(2'b01, 2'b01, 32'h10, 32'hAA, 0, 0);
    settle();
    rdy2("t1_c0", 2'b01);
    step();
    drv2(2'b00, 2'b00, 0, 0, 0, 0);
    settle();
    out2("t1_c1", 1'b1, 1'b1, 2'b01, 32'h10, 32'hAA);
    step();
    settle();
    out2("t1_c2", 1'b0, 1'b0, 2'b00, 32'h10, 32'hAA);

    // Port 1 alone (prio 1 -> 0)
    step();
    drv2(2'b10, 2'b10, 0, 0, 32'h20, 32'hBB);
    settle();
    rdy2("p1_c0", 2'b10);
    step();
    drv2(2'b00, 2'b00, 0, 0, 0, 0);
    settle();
    out2("p1_c1", 1'b1, 1'b1, 2'b10, 32'h20, 32'hBB);

    // Contention: grants alternate 0,1,0,1
    step();
    drv2(2'b11, 2'b11, 32'h100, 32'h1000, 32'h200, 32'h2000);
    settle();
    rdy2("c0", 2'b01);
    step();
    drv2(2'b11, 2'b11, 32'h101, 32'h1001, 32'h200, 32'h2000);
    settle();
    rdy2("c1", 2'b10);
    out2("c1", 1'b1, 1'b1, 2'b01, 32'h100, 32'h1000);
    step();
    drv2(2'b11, 2'b11, 32'h101, 32'h1001, 32'h201, 32'h2001);
    settle();
    rdy2("c2", 2'b01);
    out2("c2", 1'b1, 1'b1, 2'b10, 32'h200, 32'h2000);
    step();
    drv2(2'b11, 2'b11, 32'h102, 32'h1002, 32'h201, 32'h2001);
    settle();
    rdy2("c3", 2'b10);
    out2("c3", 1'b1, 1'b1, 2'b01, 32'h101, 32'h1001);
    step();
    drv2(2'b00, 2'b00, 0, 0, 0, 0);
    settle();
    out2("c4", 1'b1, 1'b1, 2'b10, 32'h201, 32'h2001);
    step();
    settle();
    out2("c5", 1'b0, 1'b0, 2'b00, 32'h201, 32'h2001);

    // Split backpressure: address drains, data waits 3 cycles
    step();
    drv2(2'b01, 2'b01, 32'h10, 32'hAA, 0, 0);
    b2.dataToMem_ready = 1'b0;
    settle();
    rdy2("s0", 2'b01);
    step();
    drv2(2'b10, 2'b10, 0, 0, 32'h30, 32'hCC);
    settle();
    out2("s1", 1'b1, 1'b1, 2'b01, 32'h10, 32'hAA);
    rdy2("s1", 2'b00);
    step();
    settle();
    out2("s2", 1'b0, 1'b1, 2'b01, 32'h10, 32'hAA);
    rdy2("s2", 2'b00);
    step();
    settle();
    out2("s3", 1'b0, 1'b1, 2'b01, 32'h10, 32'hAA);
    rdy2("s3", 2'b00);
    step();
    b2.dataToMem_ready = 1'b1;
    settle();
    out2("s4", 1'b0, 1'b1, 2'b01, 32'h10, 32'hAA);
    rdy2("s4", 2'b10);
    step();
    drv2(2'b00, 2'b00, 0, 0, 0, 0);
    settle();
    out2("s5", 1'b1, 1'b1, 2'b10, 32'h30, 32'hCC);
    step();
    settle();
    out2("s6", 1'b0, 1'b0, 2'b00, 32'h30, 32'hCC);

    // Half request: address only, never granted
    step();
    drv2(2'b10, 2'b00, 0, 0, 32'h40, 32'hDD);
    settle();
    for (int i = 0; i < 5; i++) begin
      rdy2("half", 2'b00);
      chk("half.gnt", 64'(b2.grantOut), 64'h0);
      step();
      settle();
    end
    b2.dataIn_valid = 2'b10;
    settle();
    rdy2("half_rise", 2'b10);
    step();
    drv2(2'b00, 2'b00, 0, 0, 0, 0);
    settle();
    out2("half_out", 1'b1, 1'b1, 2'b10, 32'h40, 32'hDD);
    step();
    settle();

    // Three ports: prio wraps from 2 back to 0
    step();
    b3.addrIn_valid = 3'b010;
    b3.dataIn_valid = 3'b010;
    settle();
    chk("w3_c0.rdy", 64'(b3.addrIn_ready), 64'h2);
    step();
    b3.addrIn_valid = 3'b110;
    b3.dataIn_valid = 3'b110;
    settle();
    chk("w3_c1.rdy", 64'(b3.addrIn_ready), 64'h4);
    chk("w3_c1.gnt", 64'(b3.grantOut), 64'h2);
    step();
    b3.addrIn_valid = 3'b011;
    b3.dataIn_valid = 3'b011;
    settle();
    chk("w3_c2.rdy", 64'(b3.dataIn_ready), 64'h1);
    chk("w3_c2.gnt", 64'(b3.grantOut), 64'h4);
    chk("w3_c2.addr", 64'(b3.addrOut), 64'h302);
    step();
    b3.addrIn_valid = 3'b000;
    b3.dataIn_valid = 3'b000;
    settle();
    chk("w3_c3.gnt", 64'(b3.grantOut), 64'h1);
    chk("w3_c3.data", 64'(b3.dataToMem), 64'h3000);

    // Reset with address accepted and data pending
    step();
    drv2(2'b01, 2'b01, 32'h50, 32'hEE, 0, 0);
    b2.dataToMem_ready = 1'b0;
    settle();
    rdy2("r0", 2'b01);
    step();
    drv2(2'b00, 2'b00, 0, 0, 0, 0);
    settle();
    out2("r1", 1'b1, 1'b1, 2'b01, 32'h50, 32'hEE);
    step();
    drv2(2'b10, 2'b10, 0, 0, 32'h60, 32'hFF);
    settle();
    out2("r2", 1'b0, 1'b1, 2'b01, 32'h50, 32'hEE);
    rdy2("r2", 2'b00);
    #1 rst = 1'b0;
    #1;
    out2("r_async", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    rdy2("r_async", 2'b00);
    drv2(2'b11, 2'b11, 32'h70, 32'h77, 32'h60, 32'hFF);
    b2.dataToMem_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    rdy2("r_prio0", 2'b01);
    step();
    drv2(2'b00, 2'b00, 0, 0, 0, 0);
    settle();
    out2("r_post", 1'b1, 1'b1, 2'b01, 32'h70, 32'h77);
    step();
    settle();
    out2("r_empty", 1'b0, 1'b0, 2'b00, 32'h70, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
